// File: rtl/alu_multicycle.sv
// alu_multicycle: valid/ready ALU with single-cycle logic/arith ops and
// iterative (one bit per cycle) shift-add multiply and restoring divide.
// Results and flags are registered and held in DONE until the consumer
// takes them.
module alu_multicycle #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  input  logic [3:0]       Alu_Opcode,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Remainder,
  output logic             Zero_Out,
  output logic             Carry_Out,
  output logic             Neg_Out,
  output logic             Ovf_Out,
  output logic             Div_Zero
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] BUSY = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_SHL  = 4'b0010;
  localparam logic [3:0] OP_SHR  = 4'b0011;
  localparam logic [3:0] OP_ROL  = 4'b0100;
  localparam logic [3:0] OP_ROR  = 4'b0101;
  localparam logic [3:0] OP_PASS = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_OR   = 4'b1000;
  localparam logic [3:0] OP_XOR  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_DIVU = 4'b1011;

  localparam int               CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] WIDTH_V  = WIDTH'(WIDTH);
  localparam logic [WIDTH-1:0] ZERO_V   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_V   = {WIDTH{1'b1}};

  // Control state
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       opc_q, opc_d;

  // Iterative datapath state (operands captured at acceptance)
  logic [WIDTH-1:0] mul_acc_q, mul_acc_d;
  logic [WIDTH-1:0] mul_mcand_q, mul_mcand_d;
  logic [WIDTH-1:0] mul_mplier_q, mul_mplier_d;
  logic [WIDTH-1:0] div_quo_q, div_quo_d;
  logic [WIDTH-1:0] div_rem_q, div_rem_d;
  logic [WIDTH-1:0] div_dvsr_q, div_dvsr_d;

  // Registered outputs
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             neg_q, neg_d;
  logic             ovf_q, ovf_d;
  logic             divz_q, divz_d;

  // Single-cycle ALU results
  logic [WIDTH:0]   add_s;
  logic [WIDTH:0]   sub_s;
  logic [WIDTH-1:0] rot_amt_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             alu_carry_s;
  logic             alu_ovf_s;

  // Iteration step results
  logic [WIDTH-1:0] mul_sum_s;
  logic [WIDTH:0]   div_shift_s;
  logic [WIDTH:0]   div_trial_s;
  logic [WIDTH-1:0] div_rem_step_s;
  logic [WIDTH-1:0] div_quo_step_s;

  // Single-cycle operations evaluated straight from the request inputs
  always_comb begin
    add_s       = {1'b0, Operand1} + {1'b0, Operand2};
    sub_s       = {1'b0, Operand1} - {1'b0, Operand2};
    rot_amt_s   = Operand2 % WIDTH_V;
    alu_res_s   = ZERO_V;
    alu_carry_s = 1'b0;
    alu_ovf_s   = 1'b0;
    case (Alu_Opcode)
      OP_ADD: begin
        alu_res_s   = add_s[WIDTH-1:0];
        alu_carry_s = add_s[WIDTH];
        alu_ovf_s   = (Operand1[WIDTH-1] == Operand2[WIDTH-1]) &&
                      (add_s[WIDTH-1] != Operand1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_s   = sub_s[WIDTH-1:0];
        // carry is "no borrow": set when Operand1 >= Operand2 unsigned
        alu_carry_s = ~sub_s[WIDTH];
        alu_ovf_s   = (Operand1[WIDTH-1] != Operand2[WIDTH-1]) &&
                      (sub_s[WIDTH-1] != Operand1[WIDTH-1]);
      end
      OP_SHL:  alu_res_s = (Operand2 >= WIDTH_V) ? ZERO_V : (Operand1 << Operand2);
      OP_SHR:  alu_res_s = (Operand2 >= WIDTH_V) ? ZERO_V : (Operand1 >> Operand2);
      // a zero rotate makes the complementary shift reach WIDTH, which yields 0
      OP_ROL:  alu_res_s = (Operand1 << rot_amt_s) | (Operand1 >> (WIDTH_V - rot_amt_s));
      OP_ROR:  alu_res_s = (Operand1 >> rot_amt_s) | (Operand1 << (WIDTH_V - rot_amt_s));
      OP_PASS: alu_res_s = Operand2;
      OP_AND:  alu_res_s = Operand1 & Operand2;
      OP_OR:   alu_res_s = Operand1 | Operand2;
      OP_XOR:  alu_res_s = Operand1 ^ Operand2;
      default: alu_res_s = ZERO_V;
    endcase
  end

  // One shift-add multiply step and one restoring-divide step per cycle
  always_comb begin
    mul_sum_s      = mul_acc_q + (mul_mplier_q[0] ? mul_mcand_q : ZERO_V);
    div_shift_s    = {div_rem_q, div_quo_q[WIDTH-1]};
    div_trial_s    = div_shift_s - {1'b0, div_dvsr_q};
    // a negative trial restores the shifted partial remainder; a zero
    // divisor never goes negative, giving all-ones quotient and rem=dividend
    div_rem_step_s = div_trial_s[WIDTH] ? div_shift_s[WIDTH-1:0] : div_trial_s[WIDTH-1:0];
    div_quo_step_s = {div_quo_q[WIDTH-2:0], ~div_trial_s[WIDTH]};
  end

  // FSM, iteration bookkeeping and result capture
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    opc_d        = opc_q;
    mul_acc_d    = mul_acc_q;
    mul_mcand_d  = mul_mcand_q;
    mul_mplier_d = mul_mplier_q;
    div_quo_d    = div_quo_q;
    div_rem_d    = div_rem_q;
    div_dvsr_d   = div_dvsr_q;
    result_d     = result_q;
    remainder_d  = remainder_q;
    zero_d       = zero_q;
    carry_d      = carry_q;
    neg_d        = neg_q;
    ovf_d        = ovf_q;
    divz_d       = divz_q;
    case (state_q)
      IDLE: begin
        if (In_Valid) begin
          opc_d = Alu_Opcode;
          cnt_d = {CNT_W{1'b0}};
          if (Alu_Opcode == OP_MUL) begin
            mul_acc_d    = ZERO_V;
            mul_mcand_d  = Operand1;
            mul_mplier_d = Operand2;
            state_d      = BUSY;
          end else if (Alu_Opcode == OP_DIVU) begin
            div_quo_d  = Operand1;
            div_rem_d  = ZERO_V;
            div_dvsr_d = Operand2;
            state_d    = BUSY;
          end else begin
            result_d    = alu_res_s;
            remainder_d = ZERO_V;
            zero_d      = (alu_res_s == ZERO_V);
            carry_d     = alu_carry_s;
            neg_d       = alu_res_s[WIDTH-1];
            ovf_d       = alu_ovf_s;
            divz_d      = 1'b0;
            state_d     = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (opc_q == OP_MUL) begin
          mul_acc_d    = mul_sum_s;
          mul_mcand_d  = {mul_mcand_q[WIDTH-2:0], 1'b0};
          mul_mplier_d = {1'b0, mul_mplier_q[WIDTH-1:1]};
        end else begin
          div_quo_d = div_quo_step_s;
          div_rem_d = div_rem_step_s;
        end
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          cnt_d   = {CNT_W{1'b0}};
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          if (opc_q == OP_MUL) begin
            result_d    = mul_sum_s;
            remainder_d = ZERO_V;
            zero_d      = (mul_sum_s == ZERO_V);
            neg_d       = mul_sum_s[WIDTH-1];
            divz_d      = 1'b0;
          end else begin
            result_d    = div_quo_step_s;
            remainder_d = div_rem_step_s;
            zero_d      = (div_quo_step_s == ZERO_V);
            neg_d       = div_quo_step_s[WIDTH-1];
            divz_d      = (div_dvsr_q == ZERO_V);
          end
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        if (Out_Ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous clear
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      opc_q        <= 4'b0000;
      mul_acc_q    <= ZERO_V;
      mul_mcand_q  <= ZERO_V;
      mul_mplier_q <= ZERO_V;
      div_quo_q    <= ZERO_V;
      div_rem_q    <= ZERO_V;
      div_dvsr_q   <= ZERO_V;
      result_q     <= ZERO_V;
      remainder_q  <= ZERO_V;
      zero_q       <= 1'b0;
      carry_q      <= 1'b0;
      neg_q        <= 1'b0;
      ovf_q        <= 1'b0;
      divz_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      opc_q        <= opc_d;
      mul_acc_q    <= mul_acc_d;
      mul_mcand_q  <= mul_mcand_d;
      mul_mplier_q <= mul_mplier_d;
      div_quo_q    <= div_quo_d;
      div_rem_q    <= div_rem_d;
      div_dvsr_q   <= div_dvsr_d;
      result_q     <= result_d;
      remainder_q  <= remainder_d;
      zero_q       <= zero_d;
      carry_q      <= carry_d;
      neg_q        <= neg_d;
      ovf_q        <= ovf_d;
      divz_q       <= divz_d;
    end
  end

  assign In_Ready  = (state_q == IDLE);
  assign Out_Valid = (state_q == DONE);
  assign Result    = result_q;
  assign Remainder = remainder_q;
  assign Zero_Out  = zero_q;
  assign Carry_Out = carry_q;
  assign Neg_Out   = neg_q;
  assign Ovf_Out   = ovf_q;
  assign Div_Zero  = divz_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle (WIDTH=16): directed corner cases
// plus randomized operations compared against an arithmetic reference model.
module tb_alu_multicycle;

  localparam int W = 16;
  localparam int unsigned MASK = 32'h0000_FFFF;

  logic          Clk;
  logic          Reset;
  logic          In_Valid;
  logic          In_Ready;
  logic [W-1:0]  Operand1;
  logic [W-1:0]  Operand2;
  logic [3:0]    Alu_Opcode;
  logic          Out_Valid;
  logic          Out_Ready;
  logic [W-1:0]  Result;
  logic [W-1:0]  Remainder;
  logic          Zero_Out;
  logic          Carry_Out;
  logic          Neg_Out;
  logic          Ovf_Out;
  logic          Div_Zero;

  int total;
  int bad;

  alu_multicycle #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Operand1(Operand1), .Operand2(Operand2), .Alu_Opcode(Alu_Opcode),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Result(Result),
    .Remainder(Remainder), .Zero_Out(Zero_Out), .Carry_Out(Carry_Out),
    .Neg_Out(Neg_Out), .Ovf_Out(Ovf_Out), .Div_Zero(Div_Zero)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int sx(input int unsigned v);
    return (v >= 32768) ? int'(v) - 65536 : int'(v);
  endfunction

  // Reference model from the arithmetic definition of each opcode
  function automatic void model(input int unsigned op, input int unsigned a, input int unsigned b,
                                output int unsigned res, output int unsigned rem,
                                output bit z, output bit c, output bit n, output bit v,
                                output bit dz, output int lat);
    int unsigned s;
    int          sv;
    int unsigned k;
    res = 0; rem = 0; c = 0; v = 0; dz = 0; lat = 1;
    k = b % 16;
    case (op)
      0: begin
        s = a + b; res = s & MASK; c = (s >> 16) != 0;
        sv = sx(a) + sx(b); v = (sv > 32767) || (sv < -32768);
      end
      1: begin
        res = (a - b) & MASK; c = (a >= b);
        sv = sx(a) - sx(b); v = (sv > 32767) || (sv < -32768);
      end
      2: res = (b >= 16) ? 0 : ((a << b) & MASK);
      3: res = (b >= 16) ? 0 : (a >> b);
      4: res = ((a << k) | (a >> (16 - k))) & MASK;
      5: res = ((a >> k) | (a << (16 - k))) & MASK;
      6: res = b;
      7: res = a & b;
      8: res = a | b;
      9: res = a ^ b;
      10: begin res = (a * b) & MASK; lat = 17; end
      11: begin
        lat = 17;
        if (b == 0) begin res = MASK; rem = a; dz = 1; end
        else begin res = a / b; rem = a % b; end
      end
      default: res = 0;
    endcase
    z = (res == 0);
    n = ((res >> 15) & 1) != 0;
  endfunction

  // Issue one request (called just after a falling edge) and check it through
  // the result handshake; hold>0 keeps Out_Ready low while a stray request is offered
  task automatic do_op(input int unsigned op, input int unsigned a, input int unsigned b,
                       input int hold, input string tag);
    int unsigned er, erem;
    bit ez, ec, en, ev, edz;
    int elat, lat;
    model(op, a, b, er, erem, ez, ec, en, ev, edz, elat);
    check_val({tag, ".in_ready"}, 32'(In_Ready), 32'd1);
    In_Valid   = 1'b1;
    Alu_Opcode = op[3:0];
    Operand1   = a[15:0];
    Operand2   = b[15:0];
    Out_Ready  = 1'b0;
    @(negedge Clk);
    In_Valid = 1'b0;
    Operand1 = 16'(($urandom));
    Operand2 = 16'(($urandom));
    lat = 1;
    while (!Out_Valid && lat < 60) begin
      @(negedge Clk);
      lat++;
    end
    check_val({tag, ".latency"}, 32'(lat), 32'(elat));
    check_val({tag, ".result"}, 32'(Result), er);
    check_val({tag, ".remainder"}, 32'(Remainder), erem);
    check_val({tag, ".flags"}, {27'd0, Zero_Out, Carry_Out, Neg_Out, Ovf_Out, Div_Zero},
              {27'd0, ez, ec, en, ev, edz});
    for (int i = 0; i < hold; i++) begin
      In_Valid   = 1'b1;
      Alu_Opcode = 4'($urandom_range(0, 15));
      Operand1   = 16'($urandom);
      Operand2   = 16'($urandom);
      @(negedge Clk);
      check_val({tag, ".hold_result"}, 32'(Result), er);
      check_val({tag, ".hold_state"}, {30'd0, Out_Valid, In_Ready}, {30'd0, 1'b1, 1'b0});
    end
    In_Valid  = 1'b0;
    Out_Ready = 1'b1;
    @(negedge Clk);
    Out_Ready = 1'b0;
    check_val({tag, ".released"}, {30'd0, Out_Valid, In_Ready}, {30'd0, 1'b0, 1'b1});
  endtask

  initial begin
    int seen;
    int unsigned op, a, b;
    total = 0;
    bad   = 0;
    Reset = 1'b1;
    In_Valid = 1'b0;
    Out_Ready = 1'b0;
    Alu_Opcode = 4'd0;
    Operand1 = 16'd0;
    Operand2 = 16'd0;
    #12;
    check_val("reset.outputs", {Result, Remainder}, 32'd0);
    check_val("reset.flags_hs", {25'd0, Zero_Out, Carry_Out, Neg_Out, Ovf_Out, Div_Zero, Out_Valid, In_Ready},
              32'd1);
    @(negedge Clk);
    Reset = 1'b0;

    // directed corners; first one is presented right at reset release
    do_op(0, 32'h7FFF, 32'h0001, 0, "add_ovf");
    do_op(1, 32'h0005, 32'h0005, 0, "sub_eq");
    do_op(1, 32'h0003, 32'h0005, 0, "sub_borrow");
    do_op(5, 32'h0001, 0, 0, "ror0");
    do_op(5, 32'h0001, 17, 0, "ror17");
    do_op(4, 32'h8001, 16, 0, "rol16");
    do_op(2, 32'h0001, 16, 0, "shl16");
    do_op(3, 32'h8000, 15, 0, "shr15");
    do_op(10, 32'h0100, 32'h0101, 0, "mul");
    do_op(11, 100, 7, 0, "divu");
    do_op(11, 32'h1234, 0, 0, "divu_zero");
    do_op(12, 32'h1234, 32'h5678, 0, "reserved");
    do_op(0, 32'hFFFF, 32'h0001, 5, "add_hold");

    // reset in cycle 8 of a divide discards it
    do_op(0, 1, 1, 0, "pre_rst_add");
    In_Valid = 1'b1; Alu_Opcode = 4'd11; Operand1 = 16'd5000; Operand2 = 16'd3;
    @(negedge Clk);
    In_Valid = 1'b0;
    repeat (7) @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    check_val("midrst.outputs", {Result, Remainder}, 32'd0);
    check_val("midrst.flags_hs", {25'd0, Zero_Out, Carry_Out, Neg_Out, Ovf_Out, Div_Zero, Out_Valid, In_Ready},
              32'd1);
    @(negedge Clk);
    Reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge Clk);
      if (Out_Valid) seen++;
    end
    check_val("midrst.no_out_valid", 32'(seen), 32'd0);
    do_op(0, 32'h1234, 32'h4321, 0, "post_rst_add");

    // randomized traffic
    for (int t = 0; t < 200; t++) begin
      op = $urandom_range(0, 15);
      a  = ($urandom_range(0, 4) == 0) ? (($urandom_range(0, 1) == 0) ? 32'h0000 : 32'hFFFF) : ($urandom & MASK);
      b  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 40) : ($urandom & MASK);
      do_op(op, a, b, $urandom_range(0, 3), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
